// File: rtl/core_pkg.sv
// Shared core definitions for the reorder buffer.
// Holds the default core sizing and the ROB entry record. The entry field
// widths follow the default architectural/physical register counts below.
package core_pkg;

  localparam int DEF_ROB_ENTS     = 64;
  localparam int DEF_DISP_WIDTH   = 2;
  localparam int DEF_RETIRE_WIDTH = 4;
  localparam int DEF_NUM_FUS      = 4;
  localparam int DEF_NUM_AREGS    = 32;
  localparam int DEF_NUM_PREGS    = 128;

  localparam int ROB_IDX_W = $clog2(DEF_ROB_ENTS);
  localparam int AREG_W    = $clog2(DEF_NUM_AREGS);
  localparam int PREG_W    = $clog2(DEF_NUM_PREGS);

  typedef struct packed {
    logic              valid;
    logic              complete;
    logic              exception;
    logic              br_mispred;
    logic [AREG_W-1:0] dst_reg;
    logic [PREG_W-1:0] dst_preg;
    logic [PREG_W-1:0] old_preg;
    logic [31:0]       pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// Head-window scan of the reorder buffer.
// Inputs : status bits and PCs of the RETIRE_WIDTH entries starting at head
//          (element 0 is the head entry).
// Outputs: ret_valid  - contiguous retire lanes from lane 0
//          n_retire   - number of retiring lanes
//          flush_*    - flush request, offending PC and cause
module rob_retire_select #(
  parameter int RETIRE_WIDTH = 4
) (
  input  logic [RETIRE_WIDTH-1:0]        ent_valid,
  input  logic [RETIRE_WIDTH-1:0]        ent_complete,
  input  logic [RETIRE_WIDTH-1:0]        ent_exception,
  input  logic [RETIRE_WIDTH-1:0]        ent_br_mispred,
  input  logic [RETIRE_WIDTH-1:0][31:0]  ent_pc,
  output logic [RETIRE_WIDTH-1:0]        ret_valid,
  output logic [$clog2(RETIRE_WIDTH+1)-1:0] n_retire,
  output logic                           flush_valid,
  output logic [31:0]                    flush_pc,
  output logic                           flush_is_exc
);

  localparam int NR_W = $clog2(RETIRE_WIDTH+1);

  // Set once the scan hits an entry that stops further retirement:
  // not ready, a faulting entry, or a retired mispredicted branch.
  logic blocked;

  always_comb begin
    ret_valid    = '0;
    n_retire     = '0;
    flush_valid  = 1'b0;
    flush_pc     = '0;
    flush_is_exc = 1'b0;
    blocked      = 1'b0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (!blocked) begin
        if (ent_valid[k] && ent_complete[k]) begin
          if (ent_exception[k]) begin
            // Faulting entry stays put; whole window is squashed by the flush.
            flush_valid  = 1'b1;
            flush_pc     = ent_pc[k];
            flush_is_exc = 1'b1;
            blocked      = 1'b1;
          end else begin
            ret_valid[k] = 1'b1;
            n_retire     = NR_W'(k + 1);
            if (ent_br_mispred[k]) begin
              // Branch itself commits; younger lanes are wrong-path.
              flush_valid  = 1'b1;
              flush_pc     = ent_pc[k];
              flush_is_exc = 1'b0;
              blocked      = 1'b1;
            end
          end
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit point of the out-of-order core.
// Ports:
//   clk, rst_n                     - core clock, async active-low reset
//   alloc_valid/_dst_reg/_dst_preg/_old_preg/_pc - dispatch lanes
//   alloc_ready, alloc_rob_index   - allocation acceptance and assigned indices
//   cmpl_valid/_rob_index/_exception/_br_mispred - completion ports
//   ret_valid/_dst_reg/_dst_preg/_old_preg - retire lanes (head first)
//   flush_valid, flush_pc, flush_is_exc - pipeline flush request
//   rob_empty                      - no entries held
// Handshake: a dispatch lane is accepted on a rising edge when its alloc_valid
// and alloc_ready are both high; alloc_ready depends only on registered state
// (free space and the current flush), never on alloc_valid. Retire and
// completion have no backpressure.
module reorder_buffer
  import core_pkg::*;
#(
  parameter int NUM_ROB_ENTS = DEF_ROB_ENTS,
  parameter int DISP_WIDTH   = DEF_DISP_WIDTH,
  parameter int RETIRE_WIDTH = DEF_RETIRE_WIDTH,
  parameter int NUM_FUS      = DEF_NUM_FUS,
  parameter int NUM_AREGS    = DEF_NUM_AREGS,
  parameter int NUM_PREGS    = DEF_NUM_PREGS
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [DISP_WIDTH-1:0]                       alloc_valid,
  input  logic [DISP_WIDTH-1:0][$clog2(NUM_AREGS)-1:0] alloc_dst_reg,
  input  logic [DISP_WIDTH-1:0][$clog2(NUM_PREGS)-1:0] alloc_dst_preg,
  input  logic [DISP_WIDTH-1:0][$clog2(NUM_PREGS)-1:0] alloc_old_preg,
  input  logic [DISP_WIDTH-1:0][31:0]                 alloc_pc,
  output logic                                        alloc_ready,
  output logic [DISP_WIDTH-1:0][$clog2(NUM_ROB_ENTS)-1:0] alloc_rob_index,
  input  logic [NUM_FUS-1:0]                          cmpl_valid,
  input  logic [NUM_FUS-1:0][$clog2(NUM_ROB_ENTS)-1:0] cmpl_rob_index,
  input  logic [NUM_FUS-1:0]                          cmpl_exception,
  input  logic [NUM_FUS-1:0]                          cmpl_br_mispred,
  output logic [RETIRE_WIDTH-1:0]                     ret_valid,
  output logic [RETIRE_WIDTH-1:0][$clog2(NUM_AREGS)-1:0] ret_dst_reg,
  output logic [RETIRE_WIDTH-1:0][$clog2(NUM_PREGS)-1:0] ret_dst_preg,
  output logic [RETIRE_WIDTH-1:0][$clog2(NUM_PREGS)-1:0] ret_old_preg,
  output logic                                        flush_valid,
  output logic [31:0]                                 flush_pc,
  output logic                                        flush_is_exc,
  output logic                                        rob_empty
);

  localparam int IDX   = $clog2(NUM_ROB_ENTS);
  localparam int CNT_W = IDX + 1;
  localparam int NA_W  = $clog2(DISP_WIDTH + 1);
  localparam int NR_W  = $clog2(RETIRE_WIDTH + 1);

  rob_entry_t       ents [NUM_ROB_ENTS];
  logic [IDX-1:0]   head, tail;
  logic [CNT_W-1:0] count;

  logic [RETIRE_WIDTH-1:0]       win_valid, win_complete, win_exception, win_br_mispred;
  logic [RETIRE_WIDTH-1:0][31:0] win_pc;
  logic [NR_W-1:0]               n_retire;
  logic [DISP_WIDTH-1:0]         alloc_fire;
  logic [NA_W-1:0]               n_alloc;

  // Window of entries head..head+RETIRE_WIDTH-1; the index wraps naturally.
  always_comb begin
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      win_valid[k]      = ents[head + IDX'(k)].valid;
      win_complete[k]   = ents[head + IDX'(k)].complete;
      win_exception[k]  = ents[head + IDX'(k)].exception;
      win_br_mispred[k] = ents[head + IDX'(k)].br_mispred;
      win_pc[k]         = ents[head + IDX'(k)].pc;
      ret_dst_reg[k]    = ret_valid[k] ? ents[head + IDX'(k)].dst_reg  : '0;
      ret_dst_preg[k]   = ret_valid[k] ? ents[head + IDX'(k)].dst_preg : '0;
      ret_old_preg[k]   = ret_valid[k] ? ents[head + IDX'(k)].old_preg : '0;
    end
  end

  rob_retire_select #(
    .RETIRE_WIDTH(RETIRE_WIDTH)
  ) u_retire_select (
    .ent_valid      (win_valid),
    .ent_complete   (win_complete),
    .ent_exception  (win_exception),
    .ent_br_mispred (win_br_mispred),
    .ent_pc         (win_pc),
    .ret_valid      (ret_valid),
    .n_retire       (n_retire),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .flush_is_exc   (flush_is_exc)
  );

  // Free space is judged on current count only; same-cycle retires are not
  // credited, which keeps alloc_ready independent of the retire scan width.
  assign alloc_ready = ((CNT_W'(NUM_ROB_ENTS) - count) >= CNT_W'(DISP_WIDTH)) && !flush_valid;
  assign rob_empty   = (count == '0);

  always_comb begin
    n_alloc = '0;
    for (int l = 0; l < DISP_WIDTH; l++) begin
      alloc_fire[l]      = alloc_valid[l] && alloc_ready;
      alloc_rob_index[l] = tail + IDX'(l);
      if (alloc_fire[l]) n_alloc = n_alloc + NA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < NUM_ROB_ENTS; i++) ents[i] <= '0;
    end else if (flush_valid) begin
      // Everything younger than the commit point is squashed, including
      // same-cycle completions; allocation is already held off by alloc_ready.
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < NUM_ROB_ENTS; i++) ents[i].valid <= 1'b0;
    end else begin
      for (int f = 0; f < NUM_FUS; f++) begin
        if (cmpl_valid[f] && ents[cmpl_rob_index[f]].valid) begin
          ents[cmpl_rob_index[f]].complete   <= 1'b1;
          ents[cmpl_rob_index[f]].exception  <= ents[cmpl_rob_index[f]].exception  | cmpl_exception[f];
          ents[cmpl_rob_index[f]].br_mispred <= ents[cmpl_rob_index[f]].br_mispred | cmpl_br_mispred[f];
        end
      end
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        if (ret_valid[k]) ents[head + IDX'(k)].valid <= 1'b0;
      end
      // Allocated slots are free, so they never collide with retiring entries.
      for (int l = 0; l < DISP_WIDTH; l++) begin
        if (alloc_fire[l]) begin
          ents[tail + IDX'(l)] <= '{valid: 1'b1, complete: 1'b0, exception: 1'b0,
                                   br_mispred: 1'b0, dst_reg: alloc_dst_reg[l],
                                   dst_preg: alloc_dst_preg[l], old_preg: alloc_old_preg[l],
                                   pc: alloc_pc[l]};
        end
      end
      head  <= head + IDX'(n_retire);
      tail  <= tail + IDX'(n_alloc);
      count <= count + CNT_W'(n_alloc) - CNT_W'(n_retire);
    end
  end

  // A completion must name a live entry.
  for (genvar f = 0; f < NUM_FUS; f++) begin : g_cmpl_chk
    assert property (@(posedge clk) disable iff (!rst_n)
      cmpl_valid[f] |-> ents[cmpl_rob_index[f]].valid);
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized bench for reorder_buffer against a program-order queue model.
module tb_reorder_buffer;

  localparam int ENTS = 64;
  localparam int DW   = 2;
  localparam int RW   = 4;
  localparam int NF   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0]        alloc_valid;
  logic [DW-1:0][4:0]   alloc_dst_reg;
  logic [DW-1:0][6:0]   alloc_dst_preg;
  logic [DW-1:0][6:0]   alloc_old_preg;
  logic [DW-1:0][31:0]  alloc_pc;
  logic                 alloc_ready;
  logic [DW-1:0][5:0]   alloc_rob_index;
  logic [NF-1:0]        cmpl_valid;
  logic [NF-1:0][5:0]   cmpl_rob_index;
  logic [NF-1:0]        cmpl_exception;
  logic [NF-1:0]        cmpl_br_mispred;
  logic [RW-1:0]        ret_valid;
  logic [RW-1:0][4:0]   ret_dst_reg;
  logic [RW-1:0][6:0]   ret_dst_preg;
  logic [RW-1:0][6:0]   ret_old_preg;
  logic                 flush_valid;
  logic [31:0]          flush_pc;
  logic                 flush_is_exc;
  logic                 rob_empty;

  reorder_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_valid     (alloc_valid),
    .alloc_dst_reg   (alloc_dst_reg),
    .alloc_dst_preg  (alloc_dst_preg),
    .alloc_old_preg  (alloc_old_preg),
    .alloc_pc        (alloc_pc),
    .alloc_ready     (alloc_ready),
    .alloc_rob_index (alloc_rob_index),
    .cmpl_valid      (cmpl_valid),
    .cmpl_rob_index  (cmpl_rob_index),
    .cmpl_exception  (cmpl_exception),
    .cmpl_br_mispred (cmpl_br_mispred),
    .ret_valid       (ret_valid),
    .ret_dst_reg     (ret_dst_reg),
    .ret_dst_preg    (ret_dst_preg),
    .ret_old_preg    (ret_old_preg),
    .flush_valid     (flush_valid),
    .flush_pc        (flush_pc),
    .flush_is_exc    (flush_is_exc),
    .rob_empty       (rob_empty)
  );

  // ---------------- reference model ----------------
  // Live instructions in program order; front is the oldest.
  typedef struct {
    int          idx;
    logic [4:0]  dst_reg;
    logic [6:0]  dst_preg;
    logic [6:0]  old_preg;
    logic [31:0] pc;
    bit          complete;
    bit          exc;
    bit          mis;
  } ent_t;

  ent_t rob_q[$];
  int   model_tail;
  int   alloc_n;
  int   cmpl_pos[NF];
  int   n_checks;
  int   n_pass;
  int   n_full_seen;

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    alloc_valid     = '0;
    alloc_dst_reg   = '0;
    alloc_dst_preg  = '0;
    alloc_old_preg  = '0;
    alloc_pc        = '0;
    cmpl_valid      = '0;
    cmpl_rob_index  = '0;
    cmpl_exception  = '0;
    cmpl_br_mispred = '0;
  endtask

  task automatic drive_cycle(input int p_alloc, input int p_cmpl, input int p_exc, input int p_mis);
    int cand[$];
    alloc_n = 0;
    if ($urandom_range(0, 99) < p_alloc) alloc_n = $urandom_range(1, DW);
    for (int l = 0; l < DW; l++) begin
      alloc_valid[l]    = (l < alloc_n);
      alloc_dst_reg[l]  = 5'($urandom);
      alloc_dst_preg[l] = 7'($urandom);
      alloc_old_preg[l] = 7'($urandom);
      alloc_pc[l]       = $urandom;
    end
    for (int i = 0; i < rob_q.size(); i++) if (!rob_q[i].complete) cand.push_back(i);
    for (int f = 0; f < NF; f++) begin
      cmpl_pos[f]        = -1;
      cmpl_valid[f]      = 1'b0;
      cmpl_rob_index[f]  = 6'($urandom);
      cmpl_exception[f]  = 1'b0;
      cmpl_br_mispred[f] = 1'b0;
      if (cand.size() > 0 && $urandom_range(0, 99) < p_cmpl) begin
        int j;
        j = $urandom_range(0, cand.size() - 1);
        cmpl_pos[f] = cand[j];
        cand.delete(j);
        cmpl_valid[f]      = 1'b1;
        cmpl_rob_index[f]  = 6'(rob_q[cmpl_pos[f]].idx);
        cmpl_exception[f]  = ($urandom_range(0, 99) < p_exc);
        cmpl_br_mispred[f] = ($urandom_range(0, 99) < p_mis);
      end
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  // across the coming rising edge.
  task automatic check_and_step();
    logic [RW-1:0] e_ret;
    int            n_ret;
    bit            e_flush, e_exc, e_ready;
    logic [31:0]   e_pc;
    ent_t          e;
    e_ret = '0; n_ret = 0; e_flush = 0; e_exc = 0; e_pc = '0;
    for (int k = 0; k < RW && k < rob_q.size(); k++) begin
      if (!rob_q[k].complete) break;
      if (rob_q[k].exc) begin
        e_flush = 1; e_exc = 1; e_pc = rob_q[k].pc;
        break;
      end
      e_ret[k] = 1'b1;
      n_ret++;
      if (rob_q[k].mis) begin
        e_flush = 1; e_pc = rob_q[k].pc;
        break;
      end
    end
    e_ready = ((ENTS - rob_q.size()) >= DW) && !e_flush;
    if (rob_q.size() >= ENTS - 1) n_full_seen++;

    check("ret_valid", ret_valid, e_ret);
    for (int k = 0; k < n_ret; k++) begin
      check($sformatf("ret_dst_reg[%0d]", k),  ret_dst_reg[k],  rob_q[k].dst_reg);
      check($sformatf("ret_dst_preg[%0d]", k), ret_dst_preg[k], rob_q[k].dst_preg);
      check($sformatf("ret_old_preg[%0d]", k), ret_old_preg[k], rob_q[k].old_preg);
    end
    check("flush_valid", flush_valid, e_flush);
    if (e_flush) begin
      check("flush_pc", flush_pc, e_pc);
      check("flush_is_exc", flush_is_exc, e_exc);
    end
    check("alloc_ready", alloc_ready, e_ready);
    check("rob_empty", rob_empty, rob_q.size() == 0);
    for (int l = 0; l < DW; l++)
      check($sformatf("alloc_rob_index[%0d]", l), alloc_rob_index[l], (model_tail + l) % ENTS);

    if (e_flush) begin
      rob_q.delete();
      model_tail = 0;
    end else begin
      for (int f = 0; f < NF; f++) begin
        if (cmpl_pos[f] >= 0) begin
          rob_q[cmpl_pos[f]].complete = 1;
          rob_q[cmpl_pos[f]].exc |= cmpl_exception[f];
          rob_q[cmpl_pos[f]].mis |= cmpl_br_mispred[f];
        end
      end
      for (int k = 0; k < n_ret; k++) void'(rob_q.pop_front());
      if (e_ready) begin
        for (int l = 0; l < alloc_n; l++) begin
          e.idx = model_tail; e.dst_reg = alloc_dst_reg[l]; e.dst_preg = alloc_dst_preg[l];
          e.old_preg = alloc_old_preg[l]; e.pc = alloc_pc[l];
          e.complete = 0; e.exc = 0; e.mis = 0;
          rob_q.push_back(e);
          model_tail = (model_tail + 1) % ENTS;
        end
      end
    end
  endtask

  task automatic run_phase(input int cycles, input int p_alloc, input int p_cmpl,
                           input int p_exc, input int p_mis);
    repeat (cycles) begin
      @(negedge clk);
      drive_cycle(p_alloc, p_cmpl, p_exc, p_mis);
      #1;
      check_and_step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".alloc_ready"}, alloc_ready, 1'b1);
    check({tag, ".ret_valid"},   ret_valid, '0);
    check({tag, ".flush_valid"}, flush_valid, 1'b0);
    check({tag, ".rob_empty"},   rob_empty, 1'b1);
    check({tag, ".alloc_rob_index"}, alloc_rob_index, {6'd1, 6'd0});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0; n_pass = 0; n_full_seen = 0;
    model_tail = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Fill towards full with sparse, out-of-order completions.
    run_phase(300, 90, 10, 0, 0);
    // Mixed traffic with occasional faults and mispredicts.
    run_phase(600, 60, 50, 2, 4);

    // Asynchronous reset in the middle of traffic.
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    rob_q.delete();
    model_tail = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Drain-heavy traffic: many completions, wide retires, more flushes.
    run_phase(400, 30, 80, 3, 5);
    run_phase(300, 95, 5, 0, 0);
    run_phase(300, 50, 70, 1, 3);

    check("near_full_reached", n_full_seen > 0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
